prbs_tx_ctrl: RTL and testbench

//  Sequencer for the TX PRBS9 generators (I and Q branches) of the QPSK link.

---
 rtl/prbs_tx_ctrl.sv | 137 +++++++++++++
 tb/tb_prbs_tx_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_tx_ctrl.sv
// prbs_tx_ctrl: sequencer for the I/Q PRBS9 generators of the QPSK TX path.
// Reloads the generator seeds, issues a one-cycle advance strobe every
// OS_FACTOR clocks, counts symbols and ends a burst after a programmed length
// (length 0 runs until stopped).
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active high
//   i_start       start pulse, sampled only in IDLE
//   i_stop        abort, sampled in LOAD and RUN
//   i_burst_len   symbols per burst (0 = continuous), latched on start
//   o_gen_rst     seed reload to the prbs9 instances
//   o_gen_enable  one-cycle advance strobe to the prbs9 instances
//   o_sym_valid   o_gen_enable delayed one clock (new prbs bit stable)
//   o_sym_cnt     symbols issued in the current burst
//   o_busy        high in every state except IDLE
//   o_done        one-cycle pulse at normal burst completion
module prbs_tx_ctrl #(
    parameter int unsigned OS_FACTOR = 4,
    parameter int unsigned PH_W      = 2,
    parameter int unsigned BURST_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [BURST_W-1:0] i_burst_len,
    output logic               o_gen_rst,
    output logic               o_gen_enable,
    output logic               o_sym_valid,
    output logic [BURST_W-1:0] o_sym_cnt,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [PH_W-1:0]    PH_LAST = PH_W'(OS_FACTOR - 1);
    localparam logic [BURST_W-1:0] CNT_ONE = BURST_W'(1);

    logic [1:0]         state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [BURST_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic               gen_rst_q, sym_valid_q, busy_q, done_q;
    logic               strobe_c;

    // Advance strobe on the last phase of a symbol; an abort in the same
    // cycle suppresses it, so the strobe is the one output gated by an input.
    assign strobe_c = (state_q == S_RUN) && (phase_q == PH_LAST) && !i_stop;

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        sym_cnt_d = sym_cnt_q;
        len_d     = len_q;

        case (state_q)
            S_IDLE: begin
                if (i_start && !i_stop) begin
                    state_d   = S_LOAD;
                    len_d     = i_burst_len;
                    sym_cnt_d = '0;
                end
            end
            S_LOAD: begin
                state_d = i_stop ? S_IDLE : S_RUN;
                phase_d = '0;
            end
            S_RUN: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
                    if (strobe_c) begin
                        sym_cnt_d = sym_cnt_q + CNT_ONE;
                        // Last symbol of a finite burst
                        if ((len_q != '0) && (sym_cnt_q == len_q - CNT_ONE)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            sym_cnt_q <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            sym_cnt_q <= sym_cnt_d;
            len_q     <= len_d;
        end
    end

    // Output registers, decoded from the next state so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_rst_q   <= 1'b0;
            sym_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            gen_rst_q   <= (state_d == S_LOAD);
            sym_valid_q <= strobe_c;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign o_gen_rst    = gen_rst_q;
    assign o_gen_enable = strobe_c;
    assign o_sym_valid  = sym_valid_q;
    assign o_sym_cnt    = sym_cnt_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_prbs_tx_ctrl.sv
// Self-checking bench for prbs_tx_ctrl (OS_FACTOR=4). Stimulus pushes the
// expected strobe events into a queue; a negedge monitor pops and compares
// whenever the DUT raises any strobe. A small prbs9 model driven by the DUT
// strobes checks that a re-seed restarts the bit sequence.
module tb_prbs_tx_ctrl;

    localparam int unsigned OS = 4;
    localparam int unsigned PW = 2;
    localparam int unsigned BW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_start = 1'b0;
    logic          i_stop = 1'b0;
    logic [BW-1:0] i_burst_len = '0;
    logic          o_gen_rst, o_gen_enable, o_sym_valid, o_busy, o_done;
    logic [BW-1:0] o_sym_cnt;

    prbs_tx_ctrl #(.OS_FACTOR(OS), .PH_W(PW), .BURST_W(BW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_burst_len (i_burst_len),
        .o_gen_rst   (o_gen_rst),
        .o_gen_enable(o_gen_enable),
        .o_sym_valid (o_sym_valid),
        .o_sym_cnt   (o_sym_cnt),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int            cyc;
        logic          gen_rst;
        logic          en;
        logic          valid;
        logic          done;
        logic          busy;
        logic [BW-1:0] cnt;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // prbs9 model (x^9 + x^5 + 1) fed by the DUT strobes
    logic [8:0] lfsr = 9'h000;
    logic [7:0] bits = 8'h00;
    int         nbits = 0;
    always @(posedge clk) begin
        if (o_gen_rst)         lfsr <= 9'h1FF;
        else if (o_gen_enable) lfsr <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    end
    always @(negedge clk) begin
        if (o_gen_rst) begin
            bits  <= 8'h00;
            nbits <= 0;
        end else if (o_sym_valid) begin
            bits  <= {bits[6:0], lfsr[0]};
            nbits <= nbits + 1;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && (o_gen_rst || o_gen_enable || o_sym_valid || o_done)) begin
            ev_t g, e;
            g.cyc     = cyc;
            g.gen_rst = o_gen_rst;
            g.en      = o_gen_enable;
            g.valid   = o_sym_valid;
            g.done    = o_done;
            g.busy    = o_busy;
            g.cnt     = o_sym_cnt;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d rst=%b en=%b valid=%b done=%b busy=%b cnt=%0d",
                         g.cyc, g.gen_rst, g.en, g.valid, g.done, g.busy, g.cnt);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL event got cyc=%0d rst=%b en=%b valid=%b done=%b busy=%b cnt=%0d, exp cyc=%0d rst=%b en=%b valid=%b done=%b busy=%b cnt=%0d",
                             g.cyc, g.gen_rst, g.en, g.valid, g.done, g.busy, g.cnt,
                             e.cyc, e.gen_rst, e.en, e.valid, e.done, e.busy, e.cnt);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic push(input int c, input bit r, input bit e, input bit v, input bit d, input int cnt);
        ev_t x;
        x.cyc = c; x.gen_rst = r; x.en = e; x.valid = v; x.done = d;
        x.busy = 1'b1; x.cnt = BW'(cnt);
        exp_q.push_back(x);
    endtask

    // Reload at +1, strobe at +5+4k, valid at +6+4k; done on the last valid
    task automatic push_burst(input int base, input int nsym, input bit fin);
        push(base + 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < nsym; k++) begin
            push(base + 5 + 4 * k, 0, 1, 0, 0, k);
            push(base + 6 + 4 * k, 0, 0, 1, fin && (k == nsym - 1), k + 1);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    // Start is driven in spec cycle 0 (cyc == base); burst_len then scrambled
    task automatic start_burst(input int len, output int base);
        base        = cyc;
        i_start     = 1'b1;
        i_burst_len = BW'(len);
        tick(1);
        i_start     = 1'b0;
        i_burst_len = 16'hFFFF;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int base, base2;
        logic [7:0] bits1;
        int nb1;

        // Reset values
        #1 rst = 1'b1;
        #2;
        chk("reset_strobes", {o_gen_rst, o_gen_enable, o_sym_valid, o_busy, o_done}, 5'b00000);
        chk("reset_sym_cnt", o_sym_cnt, 0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // 1: burst_len=3, hand table
        start_burst(3, base);
        push(base + 1,  1, 0, 0, 0, 0);
        push(base + 5,  0, 1, 0, 0, 0);
        push(base + 6,  0, 0, 1, 0, 1);
        push(base + 9,  0, 1, 0, 0, 1);
        push(base + 10, 0, 0, 1, 0, 2);
        push(base + 13, 0, 1, 0, 0, 2);
        push(base + 14, 0, 0, 1, 1, 3);
        wait_until(base + 14);
        chk("t1_busy_c14", o_busy, 1);
        wait_until(base + 15);
        chk("t1_idle_c15", {o_busy, o_done}, 2'b00);
        chk("t1_sym_cnt", o_sym_cnt, 3);
        tick(3);

        // 4a: start and stop together in IDLE
        i_start = 1'b1;
        i_stop  = 1'b1;
        tick(1);
        i_start = 1'b0;
        i_stop  = 1'b0;
        chk("t4_start_stop_idle", {o_busy, o_gen_rst}, 2'b00);
        tick(3);
        chk("t4_still_idle", o_busy, 0);
        chk("t4_cnt_held", o_sym_cnt, 3);

        // 4b: start held during cycles 3-14 and length changed while busy
        start_burst(3, base);
        push_burst(base, 3, 1);
        wait_until(base + 3);
        i_start     = 1'b1;
        i_burst_len = BW'(7);
        wait_until(base + 15);
        i_start = 1'b0;
        chk("t4_idle_c15", o_busy, 0);
        chk("t4_sym_cnt", o_sym_cnt, 3);
        tick(3);
        chk("t4_no_retrigger", o_busy, 0);

        // 3: burst_len=10, stop in cycle 9 (phase 3)
        start_burst(10, base);
        push_burst(base, 1, 0);
        wait_until(base + 9);
        i_stop = 1'b1;
        #1;
        chk("t3_enable_suppressed", o_gen_enable, 0);
        wait_until(base + 10);
        i_stop = 1'b0;
        chk("t3_idle_c10", {o_busy, o_done, o_sym_valid}, 3'b000);
        chk("t3_sym_cnt", o_sym_cnt, 1);
        tick(6);
        chk("t3_stays_idle", o_busy, 0);

        // 2: continuous mode for 1000 cycles
        start_burst(0, base);
        push(base + 1, 1, 0, 0, 0, 0);
        for (int k = 0; 5 + 4 * k <= 1000; k++) begin
            push(base + 5 + 4 * k, 0, 1, 0, 0, k);
            if (6 + 4 * k <= 1000) push(base + 6 + 4 * k, 0, 0, 1, 0, k + 1);
        end
        wait_until(base + 1000);
        chk("t2_sym_cnt_1000", o_sym_cnt, 249);
        chk("t2_busy_1000", o_busy, 1);
        i_stop = 1'b1;
        tick(1);
        i_stop = 1'b0;
        chk("t2_stopped", o_busy, 0);
        tick(4);

        // 5: async reset mid-RUN, then re-seed
        start_burst(0, base);
        push_burst(base, 6, 0);
        wait_until(base + 27);
        bits1 = bits;
        nb1   = nbits;
        chk("t5_bits_before_reset", {bits1, 8'(nb1)}, {8'h01, 8'd6});
        #2 rst = 1'b1;
        #1;
        chk("t5_async_reset_strobes", {o_gen_rst, o_gen_enable, o_sym_valid, o_busy, o_done}, 5'b00000);
        chk("t5_async_reset_cnt", o_sym_cnt, 0);
        tick(1);
        rst = 1'b0;
        tick(2);
        chk("t5_idle_after_reset", o_busy, 0);
        start_burst(6, base);
        push_burst(base, 6, 1);
        wait_until(base + 28);
        chk("t5_bits_after_reseed", {bits, 8'(nbits)}, {8'h01, 8'd6});
        chk("t5_sym_cnt", o_sym_cnt, 6);

        // 6: back-to-back bursts of one symbol
        start_burst(1, base);
        push_burst(base, 1, 1);
        wait_until(base + 7);
        start_burst(1, base2);
        push_burst(base2, 1, 1);
        wait_until(base2 + 8);
        chk("t6_idle", o_busy, 0);
        chk("t6_sym_cnt", o_sym_cnt, 1);

        tick(5);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
